// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low seven-segment patterns, bit order {a,b,c,d,e,f,g}
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: 4-bit value to active-low segment pattern with hex/dash and blank control
import seg7_pkg::*;
module seg7_encode (
  input  logic [3:0] i_val,
  input  logic       i_hex,
  input  logic       i_blank,
  output seg_t       o_seg
);
  seg_t w_lut;
  always_comb begin
    w_lut = SEG_BLANK;
    case (i_val)
      4'h0: w_lut = SEG_0;
      4'h1: w_lut = SEG_1;
      4'h2: w_lut = SEG_2;
      4'h3: w_lut = SEG_3;
      4'h4: w_lut = SEG_4;
      4'h5: w_lut = SEG_5;
      4'h6: w_lut = SEG_6;
      4'h7: w_lut = SEG_7;
      4'h8: w_lut = SEG_8;
      4'h9: w_lut = SEG_9;
      4'hA: w_lut = SEG_A;
      4'hB: w_lut = SEG_B;
      4'hC: w_lut = SEG_C;
      4'hD: w_lut = SEG_D;
      4'hE: w_lut = SEG_E;
      4'hF: w_lut = SEG_F;
    endcase
    o_seg = i_blank ? SEG_BLANK : (!i_hex && i_val > 4'd9) ? SEG_DASH : w_lut;
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit seven-segment driver with prescaled scan,
// anti-ghost blanking, frame-synchronous input latching and leading-zero suppression
import seg7_pkg::*;
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    hex_mode,
  input  logic                    lz_en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_hex;
  logic                    r_lz;
  logic                    w_last;
  logic                    w_wrap;
  logic                    w_blank;
  logic                    w_hi_zero;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic [3:0]              w_val;
  seg_t                    w_seg;
  assign w_last  = r_cnt == CNT_LAST;
  assign w_wrap  = w_last && r_idx == IDX_LAST;
  assign w_blank = r_cnt < CNT_BLANK || !en;
  assign w_val   = r_digits[{r_idx, 2'b00} +: 4];
  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    w_hi_zero = 1'b1;
    w_supp = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_hi_zero = w_hi_zero & (r_digits[4*k +: 4] == 4'd0);
      w_supp[k] = r_lz & w_hi_zero;
    end
  end
  seg7_encode u_enc (
    .i_val  (w_val),
    .i_hex  (r_hex),
    .i_blank(w_supp[r_idx]),
    .o_seg  (w_seg)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_digits    <= '0;
      r_dp        <= '0;
      r_hex       <= 1'b0;
      r_lz        <= 1'b0;
      seg         <= SEG_BLANK;
      dp_n        <= 1'b1;
      anode       <= '1;
      frame_start <= 1'b0;
    end else begin
      r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
      r_idx       <= w_wrap ? '0 : w_last ? r_idx + 1'b1 : r_idx;
      frame_start <= w_wrap;
      if (w_wrap) begin
        r_digits <= digits_i;
        r_dp     <= dp_i;
        r_hex    <= hex_mode;
        r_lz     <= lz_en;
      end
      seg   <= w_blank ? SEG_BLANK : w_seg;
      dp_n  <= w_blank | ~r_dp[r_idx];
      anode <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed steps with a per-cycle scoreboard plus literal spot checks
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        reset, en, hex_mode, lz_en;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  anode;
  logic        frame_start;
  int errors = 0;
  int checks = 0;
  int fs_cnt = 0;
  typedef struct packed {logic [6:0] seg; logic dp_n; logic [3:0] anode; logic fs;} out_t;
  out_t q[$];
  int m_cnt = 0, m_idx = 0;
  logic [15:0] s_dig = '0;
  logic [3:0]  s_dp = '0;
  logic        s_hex = 1'b0, s_lz = 1'b0;
  logic [3:0]  pattern [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .en(en), .hex_mode(hex_mode), .lz_en(lz_en),
    .digits_i(digits_i), .dp_i(dp_i), .seg(seg), .dp_n(dp_n), .anode(anode),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] v, input logic hex);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'b0000001; 4'h1: r = 7'b1001111; 4'h2: r = 7'b0010010; 4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100; 4'h5: r = 7'b0100100; 4'h6: r = 7'b0100000; 4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000; 4'h9: r = 7'b0000100; 4'hA: r = 7'b0001000; 4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001; 4'hD: r = 7'b1000010; 4'hE: r = 7'b0110000; default: r = 7'b0111000;
    endcase
    return (!hex && v > 4'd9) ? 7'b1111110 : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Predict the outputs of the coming edge from the model state, then compare after it.
  task automatic step();
    out_t e, got;
    logic blank, supp;
    if (reset) begin
      e = '{7'h7F, 1'b1, 4'hF, 1'b0};
      m_cnt = 0; m_idx = 0; s_dig = '0; s_dp = '0; s_hex = 1'b0; s_lz = 1'b0;
    end else begin
      blank = m_cnt < 1 || !en;
      supp  = s_lz && m_idx > 0 && (s_dig >> (m_idx * 4)) == 16'd0;
      e.anode = blank ? 4'hF : ~(4'b0001 << m_idx);
      e.seg   = (blank || supp) ? 7'h7F : enc(s_dig[m_idx*4 +: 4], s_hex);
      e.dp_n  = blank ? 1'b1 : ~s_dp[m_idx];
      e.fs    = m_cnt == 3 && m_idx == 3;
      if (e.fs) begin
        s_dig = digits_i; s_dp = dp_i; s_hex = hex_mode; s_lz = lz_en;
      end
      if (m_cnt == 3) m_idx = (m_idx + 1) % 4;
      m_cnt = (m_cnt + 1) % 4;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    got = {seg, dp_n, anode, frame_start};
    e = q.pop_front();
    fs_cnt += int'(frame_start);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL scoreboard observed=%h expected=%h", got, e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; hex_mode = 1'b0; lz_en = 1'b0; digits_i = '0; dp_i = '0;
    @(negedge clk);
    step();
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    reset = 1'b0; en = 1'b1; digits_i = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("scan_anode", 32'(anode), 32'(pattern[i]));
    end
    chk("fs_first_wrap", 32'(frame_start), 32'h1);
    fs_cnt = 0;
    run(2);
    chk("frame2_digit0", 32'(seg), 32'b1001100);
    run(6);
    digits_i = 16'h5678;
    run(6);
    chk("frame2_digit3_old", 32'(seg), 32'b1001111);
    run(2);
    chk("frame2_fs_once", 32'(fs_cnt), 32'd1);
    run(2);
    chk("frame3_digit0_new", 32'(seg), 32'b0000000);
    digits_i = 16'h00A0; lz_en = 1'b1;
    run(14 + 16);
    run(2);
    chk("lz_digit0", 32'(seg), 32'b0000001);
    run(4);
    chk("dec_dash_digit1", 32'(seg), 32'b1111110);
    run(4);
    chk("lz_digit2_blank", 32'(seg), 32'h7F);
    run(4);
    chk("lz_digit3_blank", 32'(seg), 32'h7F);
    hex_mode = 1'b1; dp_i = 4'b0100;
    run(2 + 6);
    chk("hex_a_digit1", 32'(seg), 32'b0001000);
    run(3);
    chk("dp_blank_slot", 32'(dp_n), 32'h1);
    run(1);
    chk("dp_digit2_lit", 32'(dp_n), 32'h0);
    chk("dp_digit2_anode", 32'(anode), 32'hB);
    en = 1'b0;
    fs_cnt = 0;
    run(1);
    chk("en_off_anode", 32'(anode), 32'hF);
    chk("en_off_seg", 32'(seg), 32'h7F);
    run(5);
    chk("en_off_fs", 32'(fs_cnt), 32'd1);
    en = 1'b1;
    run(10);
    reset = 1'b1;
    run(1);
    chk("midrst_anode", 32'(anode), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    run(1);
    chk("restart_blank", 32'(anode), 32'hF);
    run(1);
    chk("restart_digit0", 32'(anode), 32'hE);
    run(4);
    chk("restart_shadow0", 32'(seg), 32'b0000001);
    run(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit seven-segment display driver.
- Takes packed 4-bit digit values, per-digit decimal points and a mode select.
- Internally generates the digit scan with a refresh prescaler, anti-ghost blanking and frame-synchronous input latching.
- Drives active-low segment and anode pins directly.
- Replaces the fixed 4-digit combinational decoder + external select counter used in the score display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16, cycles at slot start with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  display enable; 0 forces all anodes off while scan keeps running.
- hex_mode  in  1  1: values 10-15 shown as A b C d E F; 0: values 10-15 shown as dash.
- lz_en  in  1  leading-zero suppression enable.
- digits_i  in  4*NUM_DIGITS  digit k in bits [4k+3:4k]; digit 0 is rightmost.
- dp_i  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- seg  out  7  {a,b,c,d,e,f,g}, active low.
- dp_n  out  1  decimal point, active low.
- anode  out  NUM_DIGITS  active low; at most one bit 0.
- frame_start  out  1  one-cycle pulse when a new frame's inputs are latched.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset. All state is cleared at the clk edge where reset=1.
- Reset values:
  - seg=7'b1111111, dp_n=1, anode all 1s, frame_start=0.
  - Prescaler cnt=0, digit index idx=0.
  - Shadow digits, dp, hex_mode and lz_en registers = 0.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - At the edge where cnt==REFRESH_DIV-1, idx advances; NUM_DIGITS-1 wraps to 0.
- Frame latch:
  - On the edge where idx wraps NUM_DIGITS-1 -> 0, the shadow registers load digits_i, dp_i, hex_mode and lz_en.
  - frame_start is registered high on that same edge for exactly 1 cycle.
  - Inputs may change at any time. A displayed frame never mixes two input snapshots.
  - Before the first wrap after reset, the shadow holds 0, so the display shows 0 (or blanks under suppression).
- Output pipeline:
  - seg, dp_n and anode are registered, computed from the current cnt, idx and shadow. Latency is 1 cycle.
  - Blank window: if cnt < BLANK_CYCLES or en==0, then anode=all 1s, seg=1111111 and dp_n=1.
  - Otherwise, anode = all 1s except bit idx = 0.
- Encoding (active low, 1 = off):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - dash=1111110, blank=1111111.
- Leading-zero suppression (shadow lz_en=1):
  - Digit k (k>=1) is blanked when it and every higher digit equal 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit still follows the shadow dp.
- Boundary conditions:
  - en toggling mid-slot takes effect on the next output register update; scan position is unaffected.
  - Reset asserted mid-slot clears everything at that edge. Scanning restarts from digit 0 with cnt=0 on the first edge after reset is deasserted.
  - In decimal mode, values 10-15 show as dash and count as nonzero for suppression.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK.
  - typedef for the 7-bit segment vector.
- One combinational sub-module seg7_encode: 4-bit value, hex_mode, blank -> 7-bit pattern.
- Scan, prescaler, shadow and suppression logic stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless stated):
- Scan timing: reset then en=1, digits_i=16'h1234.
  - anode repeats the 16-cycle pattern 1111, then 1110 for 3 cycles, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3.
  - From the second frame, seg during the 1110 phase = 1001100 (digit "4").
- Frame latching: change digits_i from 16'h1234 to 16'h5678 mid-frame.
  - The current frame still shows 1,2,3,4.
  - frame_start pulses once; the next frame shows 5,6,7,8.
- Mode and suppression: digits_i=16'h00A0, hex_mode=0, lz_en=1.
  - Digits 3 and 2 are blank (1111111), digit 1 is dash, digit 0 is 0000001.
  - With hex_mode=1, digit 1 = 0001000.
- Decimal points and enable: dp_i=4'b0100 -> dp_n=0 only during digit-2 lit cycles.
  - en=0 -> anode=1111 and seg=1111111 from the next cycle, with no change to frame_start timing.
- Reset mid-operation: assert reset for 1 cycle at idx=2, cnt=2.
  - Next cycle: all outputs at reset values, shadow=0.
  - Scan restarts at digit 0 with the full blank window.
